ps_bc_select_ctrl_p: RTL
========================

// Module: ps_bc_select_ctrl_p
// PURPOSE
//  Parametrised successor of the program-sequencer bus-connect select control.
//  Decodes the current sequencer op (immediate, stack push/pop, DM read/write, ureg transfer)
//    into registered DRR-source and DI-source selects for the bus-connect mux.
//  Adds dual-word (two-beat) transfers, multi-cycle stack-pop latency, a stall hold
//    and an optional legacy combinational DRR path.
//  Sits between the sequencer instruction decode and the bus-connect datapath.
// PARAMETERS
//  UREG_AW  8  universal-register address width
//  GRP_W    4  group field width = ureg_add[UREG_AW-1 -: GRP_W]
//  POP_LAT  1  stack read latency in cycles, 1..15; selects held this long per pop
//  DW_EN    1  1 = ps_dw honoured; 0 = ps_dw ignored, all transfers single-beat
//  DRR_REG  1  1 = drr_slct registered, aligned with di_slct; 0 = legacy combinational drr
// PORTS
//  clk              in   1        clock, all state on rising edge
//  rst_n            in   1        synchronous reset, active low
//  ps_stall         in   1        freeze: state, counter and registered outputs hold
//  ps_imminst       in   1        immediate op
//  ps_popstck       in   1        stack pop
//  ps_pshstck       in   1        stack push
//  ps_dminst        in   1        DM access
//  ps_dm_wrb        in   1        1 = DM write, 0 = DM read
//  ps_urgtrnsinst   in   1        ureg-to-ureg transfer
//  ps_dw            in   1        dual-word: second beat uses addr ^ 1
//  ps_ureg1_add     in   UREG_AW  source address for DM write / push
//  ps_ureg2_add     in   UREG_AW  source address for ureg transfer
//  ps_bc_drr_slct   out  2        DRR source select
//  ps_bc_di_slct    out  2        DI source select, always registered
//  ps_bc_ureg_add   out  UREG_AW  address driven this beat; 0 when no ureg source
//  ps_bc_beat       out  1        0 = first or only beat, 1 = second beat
//  ps_bc_busy       out  1        next edge is reserved; sequencer must not issue
// BEHAVIOUR
//  Reset (rst_n=0 at edge; wins over stall):
//    drr=di=2'b11, ureg_add=0, beat=0, state=IDLE, cnt=0. Reset mid-op aborts the beat or pop.
//  Decode priority in IDLE:
//    imm > pop > DM read > (DM write | push) > urgtrns > none.
//    imm:               di=10, drr=11
//    pop:               di=01, drr=01
//    DM read:           di=00, drr=11
//    DM write / push:   di=01, drr=grp(ureg1)
//    urgtrns:           di=01, drr=grp(ureg2)
//    none:              di=11, drr=11
//  grp map:
//    group 0 -> 10;  group 6 or 7 -> 01;  group 1 or 2 -> 00;  any other -> 11.
//  Latency: op sampled at edge k appears on outputs after edge k (1 cycle).
//    DRR_REG=0: drr follows the decode combinationally in the same cycle.
//  FSM states: IDLE, BEAT1, POP_WAIT. ps_bc_busy = (state != IDLE). All op inputs ignored when not IDLE.
//    IDLE -> BEAT1:
//      DW_EN & ps_dw & (DM write | push | urgtrns); ureg address latched.
//    BEAT1 -> IDLE:
//      outputs repeat di/drr from latched group; ureg_add = latched ^ 1, beat=1.
//    IDLE -> POP_WAIT:
//      pop with POP_LAT>1; cnt <= POP_LAT-1; pop selects held.
//    POP_WAIT:
//      cnt <= cnt-1; exit to IDLE on the edge where cnt==1. Selects held POP_LAT cycles total.
//  ps_dw on imm, pop or DM read is ignored (single beat).
//  Stall: no state or output change at that edge. An op presented under stall in IDLE is
//    not captured; the sequencer re-presents it.
//  Simultaneous push+pop resolves to pop; imm with anything resolves to imm.
// STRUCTURE
//  Shared package ps_bc_pkg:
//    2-bit select encodings (SEL_DREG=10, SEL_DAG=01, SEL_PS=00, SEL_NONE=11, DI_IMM=10,
//      DI_BUS=01, DI_DM=00, DI_NONE=11), group codes and the FSM state typedef.
//  One sub-module ps_bc_grp_decode (ureg address -> drr select), instanced per source address.
//  Top: priority decode, FSM, pop counter, output registers.
// TESTING
//  1. rst_n=0 for 2 edges mid-BEAT1 -> drr=11, di=11, ureg_add=0, busy=0; state returns to IDLE.
//  2. imm+pop+push same cycle -> next cycle di=10, drr=11, busy=0.
//  3. DM write, ureg1=0x05, ps_dw=1 ->
//       cycle 1: drr=10, di=01, ureg_add=0x05, beat=0, busy=1
//       cycle 2: ureg_add=0x04, beat=1, busy=0
//       cycle 3: idle 11/11
//  4. POP_LAT=3, single pop -> di=01, drr=01 for 3 cycles; busy=1 in cycles 1-2;
//       a push in cycle 2 is ignored.
//  5. DW transfer with ps_stall=1 for 2 cycles in BEAT1 -> outputs frozen at beat-0 values;
//       beat 1 (addr^1) emitted after stall drops.
//  6. urgtrns ureg2 = 0x1A / 0x7F / 0x35 / 0x0C -> drr = 00 / 01 / 11 / 10, di=01 each;
//       with DRR_REG=0, drr is valid in the same cycle.

Source files
------------

// File: rtl/ps_bc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ps_bc_pkg
// Description : Shared select encodings, ureg group codes and FSM state type
//               for the program-sequencer bus-connect select control.
// Revision    : 1.0 - initial release
// ============================================================================
package ps_bc_pkg;

    // DRR source select encodings
    localparam logic [1:0] SEL_DREG = 2'b10;
    localparam logic [1:0] SEL_DAG  = 2'b01;
    localparam logic [1:0] SEL_PS   = 2'b00;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // DI source select encodings
    localparam logic [1:0] DI_IMM   = 2'b10;
    localparam logic [1:0] DI_BUS   = 2'b01;
    localparam logic [1:0] DI_DM    = 2'b00;
    localparam logic [1:0] DI_NONE  = 2'b11;

    // Universal-register group codes (upper address field)
    localparam int GRP_DREG  = 0;
    localparam int GRP_PS_A  = 1;
    localparam int GRP_PS_B  = 2;
    localparam int GRP_DAG_A = 6;
    localparam int GRP_DAG_B = 7;

    // Sequencing state
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BEAT1    = 2'd1,
        ST_POP_WAIT = 2'd2
    } bc_state_e;

endpackage : ps_bc_pkg
`default_nettype wire

// File: rtl/ps_bc_grp_decode.sv
`default_nettype none
// ============================================================================
// Module      : ps_bc_grp_decode
// Description : Maps the group field of a universal-register address onto
//               the DRR source select.
// Revision    : 1.0 - initial release
// ============================================================================
module ps_bc_grp_decode
    import ps_bc_pkg::*;
#(
    parameter int UREG_AW = 8,
    parameter int GRP_W   = 4
) (
    input  logic [UREG_AW-1:0] ureg_add_i,
    output logic [1:0]         drr_slct_o
);

    logic [GRP_W-1:0] w_grp;

    assign w_grp = ureg_add_i[UREG_AW-1 -: GRP_W];

    // Group field to DRR source; unlisted groups have no DRR source
    always_comb begin
        drr_slct_o = SEL_NONE;
        if (w_grp == GRP_W'(GRP_DREG)) begin
            drr_slct_o = SEL_DREG;
        end else if ((w_grp == GRP_W'(GRP_DAG_A)) || (w_grp == GRP_W'(GRP_DAG_B))) begin
            drr_slct_o = SEL_DAG;
        end else if ((w_grp == GRP_W'(GRP_PS_A)) || (w_grp == GRP_W'(GRP_PS_B))) begin
            drr_slct_o = SEL_PS;
        end
    end

endmodule : ps_bc_grp_decode
`default_nettype wire

// File: rtl/ps_bc_select_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module      : ps_bc_select_ctrl_p
// Description : Decodes the current sequencer op into registered DRR-source
//               and DI-source selects for the bus-connect mux. Supports
//               two-beat dual-word transfers, multi-cycle stack pops, stall
//               hold and an optional combinational legacy DRR path.
// Revision    : 1.0 - initial release
// ============================================================================
module ps_bc_select_ctrl_p
    import ps_bc_pkg::*;
#(
    parameter int UREG_AW = 8,
    parameter int GRP_W   = 4,
    parameter int POP_LAT = 1,
    parameter int DW_EN   = 1,
    parameter int DRR_REG = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ps_stall_i,
    input  logic               ps_imminst_i,
    input  logic               ps_popstck_i,
    input  logic               ps_pshstck_i,
    input  logic               ps_dminst_i,
    input  logic               ps_dm_wrb_i,
    input  logic               ps_urgtrnsinst_i,
    input  logic               ps_dw_i,
    input  logic [UREG_AW-1:0] ps_ureg1_add_i,
    input  logic [UREG_AW-1:0] ps_ureg2_add_i,
    output logic [1:0]         ps_bc_drr_slct_o,
    output logic [1:0]         ps_bc_di_slct_o,
    output logic [UREG_AW-1:0] ps_bc_ureg_add_o,
    output logic               ps_bc_beat_o,
    output logic               ps_bc_busy_o
);

    // Pop counter preload: one cycle is spent on the entry edge itself
    localparam logic [3:0] c_pop_cnt_init = 4'(POP_LAT - 1);

    bc_state_e          state_q;
    logic [3:0]         cnt_q;
    logic [UREG_AW-1:0] lat_add_q;
    logic [1:0]         di_q;
    logic [1:0]         drr_q;
    logic [UREG_AW-1:0] ureg_add_q;
    logic               beat_q;

    logic [1:0]         di_d;
    logic [1:0]         drr_d;
    logic [UREG_AW-1:0] ureg_add_d;

    logic [1:0]         w_drr_u1;
    logic [1:0]         w_drr_u2;
    logic [1:0]         w_drr_lat;
    logic               w_sel_pop;
    logic               w_sel_src;
    logic               w_start_dw;

    ps_bc_grp_decode #(.UREG_AW(UREG_AW), .GRP_W(GRP_W)) u_grp_u1 (
        .ureg_add_i (ps_ureg1_add_i),
        .drr_slct_o (w_drr_u1)
    );

    ps_bc_grp_decode #(.UREG_AW(UREG_AW), .GRP_W(GRP_W)) u_grp_u2 (
        .ureg_add_i (ps_ureg2_add_i),
        .drr_slct_o (w_drr_u2)
    );

    // Latched address keeps the group of the first beat for the second beat
    ps_bc_grp_decode #(.UREG_AW(UREG_AW), .GRP_W(GRP_W)) u_grp_lat (
        .ureg_add_i (lat_add_q),
        .drr_slct_o (w_drr_lat)
    );

    // Priority decode of the presented op: imm > pop > DM read > write/push > urgtrns
    always_comb begin
        di_d       = DI_NONE;
        drr_d      = SEL_NONE;
        ureg_add_d = '0;
        w_sel_pop  = 1'b0;
        w_sel_src  = 1'b0;
        if (ps_imminst_i) begin
            di_d = DI_IMM;
        end else if (ps_popstck_i) begin
            di_d      = DI_BUS;
            drr_d     = SEL_DAG;
            w_sel_pop = 1'b1;
        end else if (ps_dminst_i && !ps_dm_wrb_i) begin
            di_d = DI_DM;
        end else if ((ps_dminst_i && ps_dm_wrb_i) || ps_pshstck_i) begin
            di_d       = DI_BUS;
            drr_d      = w_drr_u1;
            ureg_add_d = ps_ureg1_add_i;
            w_sel_src  = 1'b1;
        end else if (ps_urgtrnsinst_i) begin
            di_d       = DI_BUS;
            drr_d      = w_drr_u2;
            ureg_add_d = ps_ureg2_add_i;
            w_sel_src  = 1'b1;
        end
    end

    // Only ureg-sourced ops can be dual-word; imm, pop and DM read stay single-beat
    assign w_start_dw = (DW_EN != 0) && ps_dw_i && w_sel_src;

    // Sequencing FSM, pop counter and registered selects; stall freezes everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lat_add_q  <= '0;
            di_q       <= DI_NONE;
            drr_q      <= SEL_NONE;
            ureg_add_q <= '0;
            beat_q     <= 1'b0;
        end else if (!ps_stall_i) begin
            case (state_q)
                ST_IDLE: begin
                    di_q       <= di_d;
                    drr_q      <= drr_d;
                    ureg_add_q <= ureg_add_d;
                    beat_q     <= 1'b0;
                    if (w_start_dw) begin
                        state_q   <= ST_BEAT1;
                        lat_add_q <= ureg_add_d;
                    end else if (w_sel_pop && (POP_LAT > 1)) begin
                        state_q <= ST_POP_WAIT;
                        cnt_q   <= c_pop_cnt_init;
                    end
                end
                ST_BEAT1: begin
                    di_q       <= DI_BUS;
                    drr_q      <= w_drr_lat;
                    ureg_add_q <= lat_add_q ^ UREG_AW'(1);
                    beat_q     <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                ST_POP_WAIT: begin
                    // Pop selects stay on the outputs untouched while counting down
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        if (DRR_REG != 0) begin : g_drr_reg
            assign ps_bc_drr_slct_o = drr_q;
        end else begin : g_drr_comb
            // Legacy path: DRR leads DI by one cycle while ops are being accepted
            assign ps_bc_drr_slct_o = (state_q == ST_IDLE) ? drr_d : drr_q;
        end
    endgenerate

    assign ps_bc_di_slct_o  = di_q;
    assign ps_bc_ureg_add_o = ureg_add_q;
    assign ps_bc_beat_o     = beat_q;
    assign ps_bc_busy_o     = (state_q != ST_IDLE);

endmodule : ps_bc_select_ctrl_p
`default_nettype wire
